nvram_ioctl_port: RTL and testbench
===================================

// Module: nvram_ioctl_port
// PURPOSE
// - Host-side read/write engine for the Williams CMOS (high-score/settings) RAM.
// - Download: hps_io ioctl writes with index NV_INDEX load the CMOS RAM.
// - Upload: answers hps_io ioctl_rd requests with CMOS contents and requests saves.
// - Sits between hps_io and port B of the dual-port CMOS RAM; the CPU owns port A.
// PARAMETERS
// - ADDR_W      10      CMOS address width (DEPTH = 2**ADDR_W = 1024 nibbles)
// - DATA_W      4       CMOS data width, must be <= 8
// - NV_INDEX    16'd4   ioctl_index value selecting the NVRAM file
// - RD_LATENCY  1       ram_rdata latency in cycles after ram_addr is presented
// PORTS
// - clk_sys          in   1   system clock, all logic on rising edge
// - reset            in   1   synchronous, active-high
// - ioctl_download   in   1   hps_io download active
// - ioctl_upload     in   1   hps_io upload active
// - ioctl_index      in   16  file index
// - ioctl_wr         in   1   one-cycle write strobe
// - ioctl_rd         in   1   one-cycle read strobe
// - ioctl_addr       in   25  byte address
// - ioctl_dout       in   8   download data
// - ioctl_din        out  8   upload data to hps_io
// - ioctl_upload_req out  1   one-cycle save request to hps_io
// - save_trigger     in   1   level; rising edge requests a save (OSD close)
// - cpu_cmos_we      in   1   CPU write strobe on port A (dirty tracking)
// - ram_addr         out  ADDR_W  port B address
// - ram_we           out  1   port B write enable
// - ram_wdata        out  DATA_W  port B write data
// - ram_rdata        in   DATA_W  port B read data
// - core_hold        out  1   hold game CPU in reset during NVRAM download
// - busy             out  1   read in flight
// BEHAVIOUR
// - Reset: ioctl_din=0, ioctl_upload_req=0, ram_addr=0, ram_we=0, ram_wdata=0,
//   core_hold=0, busy=0, dirty=0, FSM=IDLE, edge detectors cleared.
// - sel = (ioctl_index==NV_INDEX); in_range = (ioctl_addr < DEPTH).
// - Write: ioctl_download&sel&ioctl_wr at T -> ram_we=1 at T+1 only, ram_addr/ram_wdata
//   registered from ioctl_addr[ADDR_W-1:0] / ioctl_dout[DATA_W-1:0]. Out of range: no write.
// - Read FSM: IDLE -> ADDR on ioctl_upload&sel&ioctl_rd (ram_addr latched, busy=1);
//   ADDR -> WAIT; WAIT counts RD_LATENCY-1 extra cycles -> CAPT; CAPT -> IDLE.
//   In CAPT ioctl_din <= {(8-DATA_W)'0, ram_rdata}, busy=0. Data valid at T+2+RD_LATENCY.
// - Out-of-range read: FSM still runs, ioctl_din <= 8'hFF.
// - ioctl_din holds value until next capture.
// - ioctl_rd while busy: ignored. ioctl_wr and ioctl_rd same cycle: write taken, read ignored.
// - Non-matching index: no RAM access, ioctl_din unchanged.
// - dirty: set by cpu_cmos_we (any cycle, including during upload); cleared at end of
//   a sel download (ioctl_download falling edge) and at end of sel upload, unless
//   cpu_cmos_we occurs in that same cycle (set wins).
// - Save: rising edge of save_trigger with dirty=1, ioctl_download=0, ioctl_upload=0
//   -> ioctl_upload_req=1 for exactly one cycle. Otherwise no request, not queued.
// - core_hold = 1 while ioctl_download&sel, and 2 cycles after its falling edge.
// - Reset mid-read: FSM to IDLE, no capture; mid-download: ram_we forced 0.
// STRUCTURE
// - Package williams2_nvram_pkg: FSM enum (IDLE, ADDR, WAIT, CAPT), NV_INDEX default,
//   CMOS ADDR_W/DATA_W constants shared with williams2.
// - Single module, no sub-module; edge detectors and latency counter inline.
// TESTING
// - Download 1024 bytes idx 4, byte i=i -> RAM[i]=i[3:0]; ram_we pulses once per ioctl_wr.
// - Upload: ioctl_rd at addr 0x3A5 with RAM=4'hC -> ioctl_din=8'h0C at T+3; addr 0x400 -> 8'hFF.
// - ioctl_rd again while busy -> ignored, ioctl_din from first read only; index 0 -> no access.
// - cpu_cmos_we once, save_trigger 0->1 -> one-cycle ioctl_upload_req; repeat with
//   dirty=0 or ioctl_download=1 -> no request.
// - Upload completes while cpu_cmos_we pulses in final cycle -> dirty stays 1.
// - reset during WAIT -> busy=0, ioctl_din=0 next cycle; core_hold high download+2 cycles.

Source files
------------

// File: rtl/williams2_nvram_pkg.sv
`default_nettype none
//============================================================================
// Package : williams2_nvram_pkg
// Shared CMOS geometry, NVRAM file index and read-FSM state encoding.
// Revision: 1.0
//============================================================================
package williams2_nvram_pkg;

    localparam int          c_CMOS_ADDR_W  = 10;
    localparam int          c_CMOS_DATA_W  = 4;
    localparam int          c_IOCTL_ADDR_W = 25;
    localparam logic [15:0] c_NV_INDEX_DEF = 16'd4;

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_ADDR = 2'd1;
    localparam logic [1:0]  c_ST_WAIT = 2'd2;
    localparam logic [1:0]  c_ST_CAPT = 2'd3;

    // True when a byte address falls inside a CMOS of 2**aw locations.
    function automatic logic addr_in_range(input logic [c_IOCTL_ADDR_W-1:0] addr,
                                           input int unsigned aw);
        return (addr >> aw) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nvram_ioctl_port.sv
`default_nettype none
//============================================================================
// Module  : nvram_ioctl_port
// Host-side ioctl download/upload engine for port B of the Williams CMOS RAM.
// Revision: 1.0
//============================================================================
module nvram_ioctl_port
    import williams2_nvram_pkg::*;
#(
    parameter int          ADDR_W     = c_CMOS_ADDR_W,
    parameter int          DATA_W     = c_CMOS_DATA_W,
    parameter logic [15:0] NV_INDEX   = c_NV_INDEX_DEF,
    parameter int          RD_LATENCY = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ioctl_download,
    input  logic                      ioctl_upload,
    input  logic [15:0]               ioctl_index,
    input  logic                      ioctl_wr,
    input  logic                      ioctl_rd,
    input  logic [c_IOCTL_ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    output logic [7:0]                ioctl_din,
    output logic                      ioctl_upload_req,
    input  logic                      save_trigger,
    input  logic                      cpu_cmos_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_we,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic                      core_hold,
    output logic                      busy
);

    localparam int c_CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RD_LATENCY - 1);

    logic [1:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               oor_q, oor_d;
    logic               busy_q, busy_d;
    logic [7:0]         din_q, din_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               dirty_q, dirty_d;
    logic               dl_q, ul_q, trig_q;
    logic               upreq_q, upreq_d;
    logic               hold_q, hold_d;

    logic w_sel, w_in_range, w_dl_now, w_ul_now;
    logic w_dl_fall, w_ul_fall, w_trig_rise, w_wr_take, w_rd_req;
    logic w_unused_dout;

    assign w_sel       = (ioctl_index == NV_INDEX);
    assign w_in_range  = addr_in_range(ioctl_addr, ADDR_W);
    assign w_dl_now    = ioctl_download & w_sel;
    assign w_ul_now    = ioctl_upload & w_sel;
    assign w_dl_fall   = dl_q & ~w_dl_now;
    assign w_ul_fall   = ul_q & ~w_ul_now;
    assign w_trig_rise = save_trigger & ~trig_q;
    assign w_wr_take   = w_dl_now & ioctl_wr & w_in_range;
    // A strobe pair on the same cycle counts as a write; the read is dropped.
    assign w_rd_req    = w_ul_now & ioctl_rd & ~ioctl_wr;
    assign w_unused_dout = ^ioctl_dout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        busy_d  = busy_q;
        din_d   = din_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;

        if (w_wr_take) begin
            we_d    = 1'b1;
            addr_d  = ioctl_addr[ADDR_W-1:0];
            wdata_d = ioctl_dout[DATA_W-1:0];
        end

        case (state_q)
            c_ST_IDLE: begin
                if (w_rd_req) begin
                    state_d = c_ST_ADDR;
                    busy_d  = 1'b1;
                    oor_d   = ~w_in_range;
                    addr_d  = ioctl_addr[ADDR_W-1:0];
                end
            end
            c_ST_ADDR: begin
                state_d = c_ST_WAIT;
                cnt_d   = '0;
            end
            c_ST_WAIT: begin
                if (cnt_q == c_CNT_LAST) begin
                    state_d = c_ST_CAPT;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_ST_CAPT: begin
                din_d   = oor_q ? 8'hFF : 8'(ram_rdata);
                busy_d  = 1'b0;
                state_d = c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // A CPU write in the same cycle as a transfer ends keeps the image dirty.
    always_comb begin
        dirty_d = dirty_q;
        if (cpu_cmos_we) begin
            dirty_d = 1'b1;
        end else if (w_dl_fall || w_ul_fall) begin
            dirty_d = 1'b0;
        end
        upreq_d = w_trig_rise & dirty_q & ~ioctl_download & ~ioctl_upload;
        hold_d  = w_dl_now | dl_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            oor_q   <= 1'b0;
            busy_q  <= 1'b0;
            din_q   <= 8'h00;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            dirty_q <= 1'b0;
            dl_q    <= 1'b0;
            ul_q    <= 1'b0;
            trig_q  <= 1'b0;
            upreq_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
            busy_q  <= busy_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            dirty_q <= dirty_d;
            dl_q    <= w_dl_now;
            ul_q    <= w_ul_now;
            trig_q  <= save_trigger;
            upreq_q <= upreq_d;
            hold_q  <= hold_d;
        end
    end

    assign ioctl_din        = din_q;
    assign ioctl_upload_req = upreq_q;
    assign ram_addr         = addr_q;
    assign ram_we           = we_q;
    assign ram_wdata        = wdata_q;
    assign core_hold        = hold_q;
    assign busy             = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nvram_ioctl_port.sv
`default_nettype none
//============================================================================
// Module  : tb_nvram_ioctl_port
// Scoreboard bench for nvram_ioctl_port with a behavioural CMOS image model.
// Revision: 1.0
//============================================================================
module tb_nvram_ioctl_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0, ioctl_upload = 1'b0;
    logic [15:0] ioctl_index = 16'd0;
    logic        ioctl_wr = 1'b0, ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic        save_trigger = 1'b0, cpu_cmos_we = 1'b0;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata = '0;
    logic        core_hold, busy;

    nvram_ioctl_port dut (
        .clk_sys(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
        .ioctl_upload_req(ioctl_upload_req), .save_trigger(save_trigger),
        .cpu_cmos_we(cpu_cmos_we), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .core_hold(core_hold),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Port B of the CMOS RAM, one cycle read latency.
    logic [3:0] tb_ram [0:1023];
    always @(posedge clk) begin
        if (ram_we) tb_ram[ram_addr] <= ram_wdata;
        ram_rdata <= tb_ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    // Reference model state
    logic [3:0] ref_mem [0:1023];
    bit         ref_dirty = 0;

    typedef struct { logic [7:0] din; int cyc; } rd_exp_t;
    typedef struct { logic [9:0] addr; logic [3:0] data; } wr_exp_t;
    rd_exp_t rq[$];
    wr_exp_t wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a capture.
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (ram_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_ram_we", 1, 0);
            end else begin
                wr_exp_t w;
                w = wq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(w.addr));
                chk("wr_data", 32'(ram_wdata), 32'(w.data));
            end
        end
        if (busy_prev && !busy && !reset) begin
            if (rq.size() == 0) begin
                chk("unexpected_capture", 1, 0);
            end else begin
                rd_exp_t r;
                r = rq.pop_front();
                chk("rd_din", 32'(ioctl_din), 32'(r.din));
                chk("rd_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
        busy_prev = busy;
    end

    function automatic bit sel_now();
        return ioctl_index == 16'd4;
    endfunction

    task automatic do_write(input logic [24:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        if (ioctl_download && sel_now() && a < 25'd1024) begin
            wr_exp_t w;
            w.addr = a[9:0]; w.data = d[3:0];
            wq.push_back(w);
            ref_mem[a[9:0]] = d[3:0];
        end
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        if (busy) chk(nm, 1, 0);
    endtask

    task automatic do_read(input logic [24:0] a);
        @(posedge clk); #1;
        ioctl_rd = 1'b1; ioctl_addr = a;
        if (ioctl_upload && sel_now()) begin
            rd_exp_t r;
            r.din = (a < 25'd1024) ? {4'h0, ref_mem[a[9:0]]} : 8'hFF;
            r.cyc = cyc + 4;
            rq.push_back(r);
        end
        @(posedge clk); #1;
        ioctl_rd = 1'b0;
        @(negedge clk);
        wait_idle("read_timeout");
    endtask

    task automatic end_download();
        @(posedge clk); #1;
        ioctl_download = 1'b0;
        if (sel_now()) ref_dirty = 0;
    endtask

    task automatic end_upload(input bit cpu_we_same);
        @(posedge clk); #1;
        ioctl_upload = 1'b0;
        cpu_cmos_we = cpu_we_same;
        if (sel_now()) ref_dirty = 0;
        if (cpu_we_same) ref_dirty = 1;
        @(posedge clk); #1;
        cpu_cmos_we = 1'b0;
    endtask

    task automatic check_save(input string nm);
        int n = 0;
        int exp_n;
        exp_n = (ref_dirty && !ioctl_download && !ioctl_upload) ? 1 : 0;
        @(posedge clk); #1;
        save_trigger = 1'b1;
        repeat (4) begin @(negedge clk); if (ioctl_upload_req) n++; end
        chk(nm, n, exp_n);
        @(posedge clk); #1;
        save_trigger = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] first_din;
        logic [24:0] a;
        int hold_n;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 4'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_din", 32'(ioctl_din), 0);
        chk("rst_upreq", 32'(ioctl_upload_req), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_core_hold", 32'(core_hold), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Full image download, byte i carries i.
        @(posedge clk); #1;
        ioctl_index = 16'd4; ioctl_download = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            do_write(25'(i), 8'(i));
            if (i == 10) chk("hold_in_download", 32'(core_hold), 1);
        end
        do_write(25'h400, 8'h5A);
        do_write(25'h1_2345, 8'h33);
        end_download();
        hold_n = 0;
        repeat (2) begin @(negedge clk); if (core_hold) hold_n++; end
        chk("hold_tail_cycles", hold_n, 2);
        @(negedge clk);
        chk("hold_released", 32'(core_hold), 0);

        // Non-matching index: no RAM access and no hold.
        @(posedge clk); #1;
        ioctl_index = 16'd0; ioctl_download = 1'b1;
        do_write(25'h010, 8'hFF);
        @(negedge clk);
        chk("hold_nonsel", 32'(core_hold), 0);
        end_download();

        // Random patch download including 0x3A5 <- C.
        @(posedge clk); #1;
        ioctl_index = 16'd4; ioctl_download = 1'b1;
        do_write(25'h3A5, 8'hAC);
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 25'($urandom_range(1024, 33554431))
                                            : 25'($urandom_range(0, 1023));
            if (a == 25'h3A5) a = 25'h3A6;
            do_write(a, 8'($urandom));
        end
        end_download();
        repeat (3) @(posedge clk);

        // Uploads
        @(posedge clk); #1;
        ioctl_upload = 1'b1;
        do_read(25'h3A5);
        chk("din_3A5", 32'(ioctl_din), 32'h0C);
        do_read(25'h400);
        chk("din_oor", 32'(ioctl_din), 32'hFF);
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 25'($urandom_range(1024, 33554431))
                                            : 25'($urandom_range(0, 1023));
            do_read(a);
        end

        // Second strobe while busy is dropped.
        do_read(25'h3A5);
        first_din = ioctl_din;
        @(posedge clk); #1;
        ioctl_rd = 1'b1; ioctl_addr = 25'h001;
        rq.push_back('{din: {4'h0, ref_mem[1]}, cyc: cyc + 4});
        @(posedge clk); #1;
        ioctl_addr = 25'h400;
        @(posedge clk); #1;
        ioctl_rd = 1'b0;
        @(negedge clk);
        wait_idle("busy_timeout");
        repeat (3) @(negedge clk);
        chk("busy_ignored_din", 32'(ioctl_din), 32'({4'h0, ref_mem[1]}));
        chk("busy_ignored_idle", 32'(busy), 0);

        // Read and write strobes together: read dropped.
        first_din = ioctl_din;
        @(posedge clk); #1;
        ioctl_rd = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h3A5;
        @(posedge clk); #1;
        ioctl_rd = 1'b0; ioctl_wr = 1'b0;
        @(negedge clk);
        chk("rdwr_no_read", 32'(busy), 0);

        // Non-matching index read: no access, din unchanged.
        @(posedge clk); #1;
        ioctl_index = 16'd0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h3A5;
        @(posedge clk); #1;
        ioctl_rd = 1'b0;
        repeat (4) @(negedge clk);
        chk("idx0_no_busy", 32'(busy), 0);
        chk("idx0_din_kept", 32'(ioctl_din), 32'(first_din));
        ioctl_index = 16'd4;
        end_upload(1'b0);

        // Save request rules
        check_save("save_clean");
        @(posedge clk); #1; cpu_cmos_we = 1'b1; ref_dirty = 1;
        @(posedge clk); #1; cpu_cmos_we = 1'b0;
        check_save("save_dirty");
        check_save("save_dirty_again");
        @(posedge clk); #1; ioctl_index = 16'd0; ioctl_download = 1'b1;
        check_save("save_during_download");
        end_download();
        ioctl_index = 16'd4;
        check_save("save_after_nonsel_dl");
        @(posedge clk); #1; ioctl_upload = 1'b1;
        do_read(25'h002);
        end_upload(1'b0);
        check_save("save_after_upload");
        @(posedge clk); #1; ioctl_upload = 1'b1;
        do_read(25'h003);
        end_upload(1'b1);
        check_save("save_cpu_we_at_upload_end");

        // Reset in WAIT
        @(posedge clk); #1; ioctl_upload = 1'b1;
        do_read(25'h7FF_0000);
        @(posedge clk); #1;
        ioctl_rd = 1'b1; ioctl_addr = 25'h005;
        @(posedge clk); #1;
        ioctl_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("wait_busy_before_rst", 32'(busy), 1);
        @(negedge clk);
        chk("rst_wait_busy", 32'(busy), 0);
        chk("rst_wait_din", 32'(ioctl_din), 0);
        @(posedge clk); #1;
        reset = 1'b0; ioctl_upload = 1'b0; ref_dirty = 0;
        repeat (6) @(negedge clk);
        chk("rst_wait_no_capture", 32'(ioctl_din), 0);

        chk("rd_queue_empty", rq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
